vga_plot_receiver: RTL and testbench

- Consumes the DESim pixel-plot interface (VGA_X, VGA_Y, VGA_COLOR, plot) that a drawing block such as vga_demo produces.
- Each accepted plot is converted into a linear framebuffer write and queued in an 8-entry FIFO.
- The queue drains to a pixel-memory write port under an ack handshake.
- A clear command sweeps the whole framebuffer to a fixed colour. Plots arriving during the sweep stay queued and are written after it.

---
 rtl/vga_plot_receiver.sv | 182 ++++++++++++++++++
 tb/tb_vga_plot_receiver.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_receiver.sv
// vga_plot_receiver
//   Turns the DESim pixel-plot stream (VGA_X/VGA_Y/VGA_COLOR + plot strobe)
//   into linear framebuffer writes. Accepted plots are queued in a small FIFO
//   and drained to a pixel-memory write port under a req/ack handshake.
//   A clear command sweeps the whole frame to CLEAR_COLOR; plots arriving
//   during the sweep stay queued and are written afterwards.
//
// Ports
//   CLOCK_50, Resetn        clock (rising edge), async active-low reset
//   VGA_X/VGA_Y/VGA_COLOR   plot coordinates and colour, sampled with plot
//   plot                    one-cycle write strobe, never back-pressured
//   clear                   full-frame clear request (level, sampled per cycle)
//   mem_addr/mem_data       registered write address (Y*XRES+X) and data
//   mem_we                  registered write request, held until mem_ack
//   mem_ack                 memory accepted the current request
//   busy                    queue non-empty, write/clear active, or clear pending
//   overflow                sticky: a plot was lost to a full queue
//   drop_count              saturating count of lost plots (full or clipped)
module vga_plot_receiver #(
    parameter int             XRES        = 160,
    parameter int             YRES        = 120,
    parameter int             XW          = 8,
    parameter int             YW          = 7,
    parameter int             CW          = 24,
    parameter int             AW          = 15,
    parameter int             DEPTH       = 8,
    parameter logic [CW-1:0]  CLEAR_COLOR = 24'h000000
) (
    input  logic          CLOCK_50,
    input  logic          Resetn,
    input  logic [XW-1:0] VGA_X,
    input  logic [YW-1:0] VGA_Y,
    input  logic [CW-1:0] VGA_COLOR,
    input  logic          plot,
    input  logic          clear,
    output logic [AW-1:0] mem_addr,
    output logic [CW-1:0] mem_data,
    output logic          mem_we,
    input  logic          mem_ack,
    output logic          busy,
    output logic          overflow,
    output logic [15:0]   drop_count
);

    localparam int            PW      = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(XRES * YRES - 1);
    localparam logic [AW-1:0] XRES_A  = AW'(XRES);
    localparam logic [XW:0]   XRES_X  = (XW + 1)'(XRES);
    localparam logic [YW:0]   YRES_Y  = (YW + 1)'(YRES);
    localparam logic [PW:0]   FULL_N  = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] fifo_addr [DEPTH];
    logic [CW-1:0] fifo_data [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          empty, full, in_range, push, pop, drop, lost;
    logic [AW-1:0] plot_addr;
    logic          clr_pend, clr_pend_nx;
    logic [AW-1:0] addr_nx;
    logic [CW-1:0] data_nx;
    logic          we_nx;
    logic          start_clr, take_entry, go_idle, at_boundary;

    assign empty     = (count == '0);
    assign full      = (count == FULL_N);
    assign in_range  = ({1'b0, VGA_X} < XRES_X) && ({1'b0, VGA_Y} < YRES_Y);
    assign plot_addr = AW'(VGA_Y) * XRES_A + AW'(VGA_X);

    // A full queue still takes a plot when the FSM pops on the same edge.
    assign push = plot && in_range && (!full || pop);
    assign lost = plot && in_range && full && !pop;
    assign drop = plot && !push;

    assign busy = !empty || (state != IDLE) || clr_pend;

    // Next-state / output-register logic.
    always_comb begin
        state_nx    = state;
        addr_nx     = mem_addr;
        data_nx     = mem_data;
        we_nx       = mem_we;
        pop         = 1'b0;
        start_clr   = 1'b0;
        take_entry  = 1'b0;
        go_idle     = 1'b0;
        at_boundary = 1'b0;
        // A clear request during a sweep is ignored, otherwise it latches.
        clr_pend_nx = clr_pend | (clear && (state != CLEAR));

        case (state)
            IDLE:  at_boundary = 1'b1;
            WRITE: at_boundary = mem_ack;
            CLEAR: begin
                if (mem_ack) begin
                    if (mem_addr < LAST) begin
                        addr_nx = mem_addr + AW'(1);
                    end else begin
                        clr_pend_nx = 1'b0;
                        if (!empty) take_entry = 1'b1;
                        else        go_idle    = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // Idle or a just-acked write: pending clear first, then the queue.
        if (at_boundary) begin
            if (clr_pend)    start_clr  = 1'b1;
            else if (!empty) take_entry = 1'b1;
            else             go_idle    = 1'b1;
        end

        if (start_clr) begin
            addr_nx  = '0;
            data_nx  = CLEAR_COLOR;
            we_nx    = 1'b1;
            state_nx = CLEAR;
        end
        if (take_entry) begin
            addr_nx  = fifo_addr[rd_ptr];
            data_nx  = fifo_data[rd_ptr];
            we_nx    = 1'b1;
            pop      = 1'b1;
            state_nx = WRITE;
        end
        if (go_idle) begin
            we_nx    = 1'b0;
            state_nx = IDLE;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state    <= IDLE;
            mem_addr <= '0;
            mem_data <= '0;
            mem_we   <= 1'b0;
            clr_pend <= 1'b0;
        end else begin
            state    <= state_nx;
            mem_addr <= addr_nx;
            mem_data <= data_nx;
            mem_we   <= we_nx;
            clr_pend <= clr_pend_nx;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW + 1)'(push) - (PW + 1)'(pop);
        end
    end

    // Queue storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            fifo_addr[wr_ptr] <= plot_addr;
            fifo_data[wr_ptr] <= VGA_COLOR;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (lost) overflow <= 1'b1;
            if (drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_vga_plot_receiver.sv
// Scoreboard bench for vga_plot_receiver: stimulus pushes expected writes,
// a negedge monitor pops and compares every accepted memory write.
module tb_vga_plot_receiver;

    localparam int XW = 8, YW = 7, CW = 24, AW = 15;

    logic          CLOCK_50 = 1'b0;
    logic          Resetn   = 1'b0;
    logic [XW-1:0] VGA_X    = '0;
    logic [YW-1:0] VGA_Y    = '0;
    logic [CW-1:0] VGA_COLOR = '0;
    logic          plot     = 1'b0;
    logic          clear    = 1'b0;
    logic          mem_ack  = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [CW-1:0] mem_data;
    logic          mem_we;
    logic          busy;
    logic          overflow;
    logic [15:0]   drop_count;

    vga_plot_receiver dut (
        .CLOCK_50   (CLOCK_50),
        .Resetn     (Resetn),
        .VGA_X      (VGA_X),
        .VGA_Y      (VGA_Y),
        .VGA_COLOR  (VGA_COLOR),
        .plot       (plot),
        .clear      (clear),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_we     (mem_we),
        .mem_ack    (mem_ack),
        .busy       (busy),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [CW-1:0] data;
    } wr_t;

    wr_t sb[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  we_cycles   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Advance n rising edges, then step off the edge to drive inputs.
    task automatic tick(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset();
        Resetn  = 1'b0;
        plot    = 1'b0;
        clear   = 1'b0;
        mem_ack = 1'b0;
        sb.delete();
        tick(2);
        Resetn = 1'b1;
        tick(1);
    endtask

    task automatic send_plot(input logic [XW-1:0] x, input logic [YW-1:0] y,
                             input logic [CW-1:0] c, input bit exp_wr, input int exp_addr);
        VGA_X     = x;
        VGA_Y     = y;
        VGA_COLOR = c;
        plot      = 1'b1;
        if (exp_wr) sb.push_back(wr_t'{addr: AW'(exp_addr), data: c});
        tick(1);
        plot = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge CLOCK_50);
            n++;
        end
        #1;
        check(name, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic hold_chk(input string name, input int addr, input logic [CW-1:0] data);
        @(negedge CLOCK_50);
        check({name, "_we"},   32'(mem_we),   32'd1);
        check({name, "_addr"}, 32'(mem_addr), 32'(addr));
        check({name, "_data"}, 32'(mem_data), 32'(data));
    endtask

    int  t_addr[10] = '{10, 171, 332, 493, 654, 815, 976, 1137, 1298, 1459};
    int  we0;
    bit  found;
    wr_t e;

    initial begin
        // Monitor: every accepted write must match the head of the scoreboard.
        fork
            forever begin
                @(negedge CLOCK_50);
                if (Resetn && mem_we) we_cycles++;
                if (Resetn && mem_we && mem_ack) begin
                    vectors++;
                    if (sb.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_write: addr=%0d data=%h, none expected", mem_addr, mem_data);
                    end else begin
                        e = sb.pop_front();
                        if (mem_addr !== e.addr || mem_data !== e.data) begin
                            miscompares++;
                            $display("FAIL write: got addr=%0d data=%h, want addr=%0d data=%h",
                                     mem_addr, mem_data, e.addr, e.data);
                        end
                    end
                end
            end
        join_none

        // Reset state
        #1;
        check("rst_we",    32'(mem_we),     32'd0);
        check("rst_addr",  32'(mem_addr),   32'd0);
        check("rst_data",  32'(mem_data),   32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_ovf",   32'(overflow),   32'd0);
        check("rst_drops", 32'(drop_count), 32'd0);
        do_reset();

        // Single plot, ack high: one write cycle, then idle
        mem_ack = 1'b1;
        we0 = we_cycles;
        send_plot(8'd5, 7'd2, 24'hFF0000, 1'b1, 325);
        wait_drain("single_drain", 20);
        tick(3);
        check("single_we_cycles", 32'(we_cycles - we0), 32'd1);
        check("single_busy",      32'(busy),   32'd0);
        check("single_we_low",    32'(mem_we), 32'd0);

        // Ten plots with ack low: 1 in output reg, 8 queued, 10th lost
        do_reset();
        for (int i = 0; i < 10; i++)
            send_plot(8'(10 + i), 7'(i), 24'(32'hC00000 + i), i < 9, t_addr[i]);
        check("ovf_flag",  32'(overflow),   32'd1);
        check("ovf_drops", 32'(drop_count), 32'd1);
        check("ovf_busy",  32'(busy),       32'd1);
        check("ovf_head",  32'(mem_addr),   32'd10);
        mem_ack = 1'b1;
        wait_drain("ovf_drain", 40);
        tick(2);
        check("ovf_idle_we", 32'(mem_we), 32'd0);
        check("ovf_sticky",  32'(overflow), 32'd1);

        // Clipping at both edges of the frame
        do_reset();
        mem_ack = 1'b1;
        send_plot(8'd160, 7'd0,   24'h123456, 1'b0, 0);
        send_plot(8'd0,   7'd120, 24'h654321, 1'b0, 0);
        tick(5);
        check("clip_drops", 32'(drop_count), 32'd2);
        check("clip_ovf",   32'(overflow),   32'd0);
        check("clip_busy",  32'(busy),       32'd0);

        // Full clear; plots and a redundant clear arrive mid-sweep
        do_reset();
        mem_ack = 1'b1;
        for (int a = 0; a < 19200; a++) sb.push_back(wr_t'{addr: AW'(a), data: 24'h000000});
        we0 = we_cycles;
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        tick(1000);
        clear = 1'b1;
        send_plot(8'd10,  7'd20,  24'h123456, 1'b1, 3210);
        clear = 1'b0;
        send_plot(8'd159, 7'd119, 24'hABCDEF, 1'b1, 19199);
        wait_drain("clear_drain", 25000);
        tick(20);
        check("clear_we_cycles", 32'(we_cycles - we0), 32'd19202);
        check("clear_busy",      32'(busy), 32'd0);

        // Handshake: ack low 3 cycles holds the request 4 cycles, no gaps after
        do_reset();
        send_plot(8'd1, 7'd1, 24'h111111, 1'b1, 161);
        send_plot(8'd2, 7'd1, 24'h222222, 1'b1, 162);
        VGA_X = 8'd3; VGA_Y = 7'd1; VGA_COLOR = 24'h333333; plot = 1'b1;
        sb.push_back(wr_t'{addr: AW'(163), data: 24'h333333});
        hold_chk("hold0", 161, 24'h111111);
        @(posedge CLOCK_50); #1; plot = 1'b0;
        hold_chk("hold1", 161, 24'h111111);
        hold_chk("hold2", 161, 24'h111111);
        @(posedge CLOCK_50); #1; mem_ack = 1'b1;
        hold_chk("hold3", 161, 24'h111111);
        hold_chk("b2b_b", 162, 24'h222222);
        hold_chk("b2b_c", 163, 24'h333333);
        @(negedge CLOCK_50);
        check("b2b_end_we", 32'(mem_we), 32'd0);
        wait_drain("hs_drain", 10);

        // Reset pulsed mid-clear at address 500
        do_reset();
        mem_ack = 1'b1;
        send_plot(8'd200, 7'd5, 24'h777777, 1'b0, 0);
        for (int a = 0; a < 19200; a++) sb.push_back(wr_t'{addr: AW'(a), data: 24'h000000});
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 2000 && !found; n++) begin
            @(negedge CLOCK_50);
            if (mem_we && mem_addr == AW'(500)) found = 1'b1;
        end
        check("mid_reach_500", 32'(found), 32'd1);
        #1;
        Resetn = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_we",    32'(mem_we),     32'd0);
        check("mid_rst_addr",  32'(mem_addr),   32'd0);
        check("mid_rst_data",  32'(mem_data),   32'd0);
        check("mid_rst_busy",  32'(busy),       32'd0);
        check("mid_rst_drops", 32'(drop_count), 32'd0);
        @(posedge CLOCK_50); #1;
        Resetn = 1'b1;
        we0 = we_cycles;
        tick(50);
        check("mid_no_resume", 32'(we_cycles - we0), 32'd0);
        check("mid_busy",      32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
